rxf_fa_start_ctrl: RTL
======================

// Module: rxf_fa_start_ctrl
// PURPOSE
//  Per-carrier (FA) start sequencer for the 3GF RX-filter output path.
//  - Arms on an RX start, then waits for a rising edge of each FA's selected ADC Tclk.
//  - Counts a programmable number of PnClk2En strobes, then raises a per-FA data enable.
//  - Keeps a per-FA output sample index running for downstream capture and compare logic.
//  Sits between the RX start source (L1 or demod) and the RXF output consumers.
// PARAMETERS
//  NUM_FA   4   number of carriers sequenced
//  NUM_ADC  6   number of ADC Tclk inputs; iAdcSel codes >= NUM_ADC are illegal
//  SEL_W    3   width of each ADC select field
//  OFS_W    8   width of each start-offset field
//  CNT_W    16  width of each sample counter
// PORTS
//  clk           in   1              system clock; all inputs sampled on its rising edge
//  reset         in   1              asynchronous, active-high reset
//  iRxStart      in   1              RX start level; its rising edge arms the sequencer
//  iAbort        in   1              synchronous abort; returns all FAs to IDLE
//  iTclk         in   NUM_ADC        per-ADC Tclk level, synchronous to clk
//  iPnClk2En     in   1              one-cycle chip-x2 strobe
//  iFaEn         in   NUM_FA         per-FA enable, latched at start
//  iAdcSel       in   NUM_FA*SEL_W   per-FA ADC select, latched at start
//  iStartOfs     in   NUM_FA*OFS_W   per-FA strobe offset, latched at start
//  oFaDataEn     out  NUM_FA         per-FA output-valid enable
//  oFaSampleCnt  out  NUM_FA*CNT_W   per-FA count of strobes seen while in RUN
//  oFaState      out  NUM_FA*2       per-FA state: 0=IDLE 1=WAIT_TCLK 2=WAIT_OFS 3=RUN
//  oBusy         out  1              OR of (state != IDLE) over all FAs
//  oAllRun       out  1              one-cycle pulse when the last enabled FA enters RUN
//  oRestart      out  1              one-cycle pulse on re-arm while busy
//  oCfgErr       out  NUM_FA         sticky; set when an enabled FA has iAdcSel >= NUM_ADC
// BEHAVIOUR
//  Reset: all outputs 0, all FSMs IDLE, edge-detect flops 0, latched config 0.
//  Edge detection
//   - startEdge = iRxStart & ~iRxStart_d.
//   - tclkEdge[k] = iTclk[k] & ~iTclk_d[k].
//   - An event detected in cycle n changes state/outputs at the clk edge ending cycle n.
//  startEdge
//   - Latches iFaEn, iAdcSel and iStartOfs.
//   - Clears oCfgErr and all counters.
//   - Each enabled FA with a legal select goes to WAIT_TCLK; others stay IDLE.
//   - Illegal-select FAs set their oCfgErr bit.
//  WAIT_TCLK -> WAIT_OFS on tclkEdge[sel].
//   - A strobe in that same cycle is not counted.
//   - If ofs == 0, the FA goes straight to RUN instead.
//  WAIT_OFS: ofsCnt counts iPnClk2En strobes; on the strobe where ofsCnt+1 == ofs -> RUN.
//  RUN
//   - oFaDataEn = 1.
//   - oFaSampleCnt increments on each strobe and saturates at 2^CNT_W-1.
//  oAllRun
//   - Pulses in the cycle where every latched-enabled, legal FA is in RUN and was not the cycle before.
//   - Does not pulse if no FA is enabled.
//  Re-arm: startEdge while oBusy=1
//   - Treated as a fresh start: config relatched, counters cleared.
//   - oRestart pulses for one cycle.
//  iAbort
//   - Next cycle all FAs IDLE, oFaDataEn = 0, counters cleared; oCfgErr is kept.
//   - Abort wins over a simultaneous startEdge; that start is dropped.
//  Config change in the middle of a run is ignored until the next startEdge.
//  Two FAs may select the same ADC and then align on the same Tclk edge.
//  Async reset mid-run: immediate return to reset values; no pulse outputs fire.
// TESTING
//  T1: FA0 en, sel=2, ofs=12; start, Tclk[2] edge, then strobes every 2 clk
//      -> oFaDataEn[0] rises one clk after the 12th strobe; oFaSampleCnt[0] = 0 at that point.
//  T2: all 4 FAs en, sels 0/1/2/3, ofs 12/12/5/0, staggered Tclk edges
//      -> each FA enters RUN independently; oAllRun pulses once, when the last FA enters RUN.
//  T3: FA1 sel=7 with NUM_ADC=6 -> FA1 stays IDLE and oCfgErr[1] = 1;
//      oAllRun still fires for the other enabled FAs.
//  T4: second start edge after 100 strobes in RUN
//      -> oRestart pulses; FSMs return to WAIT_TCLK; counts = 0; new ofs used.
//  T5: iAbort in the same cycle as a start edge, then abort during WAIT_OFS
//      -> state stays IDLE; then all IDLE next cycle and oFaDataEn = 0.
//  T6: Tclk edge coincident with a strobe, ofs=1
//      -> that strobe is not counted; RUN is entered on the next strobe.
//      Run 2^16+5 strobes -> oFaSampleCnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/rxf_fa_start_ctrl.sv
// Per-carrier start sequencer for the RX-filter output path: arm on RX start,
// wait for the selected ADC Tclk edge, count an offset of PnClk2En strobes, then run.
module rxf_fa_start_ctrl #(
  parameter int NUM_FA  = 4,
  parameter int NUM_ADC = 6,
  parameter int SEL_W   = 3,
  parameter int OFS_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iRxStart,
  input  logic                    iAbort,
  input  logic [NUM_ADC-1:0]      iTclk,
  input  logic                    iPnClk2En,
  input  logic [NUM_FA-1:0]       iFaEn,
  input  logic [NUM_FA*SEL_W-1:0] iAdcSel,
  input  logic [NUM_FA*OFS_W-1:0] iStartOfs,
  output logic [NUM_FA-1:0]       oFaDataEn,
  output logic [NUM_FA*CNT_W-1:0] oFaSampleCnt,
  output logic [NUM_FA*2-1:0]     oFaState,
  output logic                    oBusy,
  output logic                    oAllRun,
  output logic                    oRestart,
  output logic [NUM_FA-1:0]       oCfgErr
);

  localparam int                 SEL_SPAN  = 1 << SEL_W;
  localparam logic [SEL_W:0]     ADC_LIMIT = (SEL_W+1)'(NUM_ADC);
  localparam logic [OFS_W-1:0]   OFS_ONE   = 1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TCLK = 2'd1,
    ST_WAIT_OFS  = 2'd2,
    ST_RUN       = 2'd3
  } fa_state_e;

  logic                    rx_start_q;
  logic [NUM_ADC-1:0]      tclk_q;
  logic                    start_edge;
  logic                    arm;
  logic [NUM_ADC-1:0]      tclk_edge;
  logic [SEL_SPAN-1:0]     tclk_edge_ext;
  logic [NUM_FA-1:0]       sel_legal;
  logic [NUM_FA-1:0]       active_q;
  logic [NUM_FA-1:0]       cfg_err_q;
  logic [NUM_FA*SEL_W-1:0] sel_q;
  logic [NUM_FA*OFS_W-1:0] ofs_q;
  logic [NUM_FA-1:0]       run_vec;
  logic [NUM_FA-1:0]       busy_vec;
  logic                    all_run;
  logic                    all_run_q;
  logic                    restart_q;

  assign start_edge    = iRxStart & ~rx_start_q;
  assign arm           = start_edge & ~iAbort;
  assign tclk_edge     = iTclk & ~tclk_q;
  // Widened so any select code indexes safely; illegal codes never reach WAIT_TCLK.
  assign tclk_edge_ext = SEL_SPAN'(tclk_edge);

  for (genvar gi = 0; gi < NUM_FA; gi++) begin : g_legal
    assign sel_legal[gi] = ({1'b0, iAdcSel[gi*SEL_W +: SEL_W]} < ADC_LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_start_q <= 1'b0;
      tclk_q     <= '0;
      all_run_q  <= 1'b0;
      restart_q  <= 1'b0;
      active_q   <= '0;
      cfg_err_q  <= '0;
      sel_q      <= '0;
      ofs_q      <= '0;
    end else begin
      rx_start_q <= iRxStart;
      tclk_q     <= iTclk;
      all_run_q  <= all_run;
      restart_q  <= arm & oBusy;
      if (arm) begin
        active_q  <= iFaEn & sel_legal;
        cfg_err_q <= iFaEn & ~sel_legal;
        sel_q     <= iAdcSel;
        ofs_q     <= iStartOfs;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_FA; gi++) begin : g_fa
    fa_state_e        state_q, state_d;
    logic [OFS_W-1:0] ofs_cnt_q, ofs_cnt_d;
    logic [CNT_W-1:0] smp_q, smp_d;
    logic [SEL_W-1:0] sel;
    logic [OFS_W-1:0] ofs;
    logic             tclk_hit;

    assign sel      = sel_q[gi*SEL_W +: SEL_W];
    assign ofs      = ofs_q[gi*OFS_W +: OFS_W];
    assign tclk_hit = tclk_edge_ext[sel];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q   <= ST_IDLE;
        ofs_cnt_q <= '0;
        smp_q     <= '0;
      end else begin
        state_q   <= state_d;
        ofs_cnt_q <= ofs_cnt_d;
        smp_q     <= smp_d;
      end
    end

    // Abort outranks start; start outranks normal sequencing and uses live config.
    always_comb begin
      state_d   = state_q;
      ofs_cnt_d = ofs_cnt_q;
      smp_d     = smp_q;
      if (iAbort) begin
        state_d   = ST_IDLE;
        ofs_cnt_d = '0;
        smp_d     = '0;
      end else if (start_edge) begin
        state_d   = (iFaEn[gi] && sel_legal[gi]) ? ST_WAIT_TCLK : ST_IDLE;
        ofs_cnt_d = '0;
        smp_d     = '0;
      end else begin
        case (state_q)
          ST_WAIT_TCLK: begin
            if (tclk_hit) begin
              ofs_cnt_d = '0;
              state_d   = (ofs == '0) ? ST_RUN : ST_WAIT_OFS;
            end
          end
          ST_WAIT_OFS: begin
            if (iPnClk2En) begin
              if (ofs_cnt_q + OFS_ONE == ofs) state_d = ST_RUN;
              else                            ofs_cnt_d = ofs_cnt_q + OFS_ONE;
            end
          end
          ST_RUN: begin
            if (iPnClk2En && smp_q != '1) smp_d = smp_q + CNT_ONE;
          end
          default: ;
        endcase
      end
    end

    assign oFaState[gi*2 +: 2]         = state_q;
    assign oFaSampleCnt[gi*CNT_W +: CNT_W] = smp_q;
    assign run_vec[gi]                 = (state_q == ST_RUN);
    assign busy_vec[gi]                = (state_q != ST_IDLE);
  end

  assign all_run   = (|active_q) && ((run_vec & active_q) == active_q);
  assign oFaDataEn = run_vec;
  assign oBusy     = |busy_vec;
  assign oAllRun   = all_run & ~all_run_q;
  assign oRestart  = restart_q;
  assign oCfgErr   = cfg_err_q;

endmodule
